// File: rtl/mem_access_stage.sv
// MEM stage: EX/MEM pipeline register, data-RAM pin drive, load wait-state FSM,
// access checking with fault reporting, MEM/WB register and MEM-stage forwarding.
module mem_access_stage #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 32,
  parameter int RD_LATENCY = 1,
  parameter int REG_W      = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  input  logic [REG_W-1:0]  ex_rd,
  output logic [DATA_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              mem_stall,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              fault,
  output logic [DATA_W-1:0] fault_addr
);

  typedef enum logic {S_RUN = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [2:0]        LAT     = 3'(RD_LATENCY);
  localparam logic [DATA_W-1:0] DEPTH_V = DATA_W'(DEPTH);

  logic              r_valid;
  logic [DATA_W-1:0] r_alu_result;
  logic [DATA_W-1:0] r_store_data;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_reg_write;
  logic              r_mem_to_reg;
  logic [REG_W-1:0]  r_rd;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_cnt;
  logic [2:0]        w_cnt_nxt;
  logic              w_stall;

  logic [DATA_W-1:0] w_index;
  logic              w_access;
  logic              w_misalign;
  logic              w_range;
  logic              w_bad;
  logic              w_load_go;

  assign w_index    = {2'b00, r_alu_result[DATA_W-1:2]};
  assign w_access   = r_mem_read | r_mem_write;
  assign w_misalign = w_access & (r_alu_result[1:0] != 2'b00);
  assign w_range    = w_access & (w_index >= DEPTH_V);
  assign w_bad      = w_misalign | w_range;
  assign w_load_go  = r_valid & r_mem_read & ~w_bad;

  assign mem_address    = w_index;
  assign mem_write_data = r_store_data;
  assign mem_write      = r_valid & r_mem_write & ~w_bad;
  assign mem_read       = w_load_go;
  assign mem_stall      = w_stall;

  // Loads are never forwarded from here: their data only exists at completion.
  assign fwd_valid = r_valid & r_reg_write & ~r_mem_to_reg & ~w_bad;
  assign fwd_rd    = r_rd;
  assign fwd_data  = r_alu_result;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_load_go && (LAT != 3'd0)) begin
          w_stall     = 1'b1;
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = LAT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 3'd1) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid      <= 1'b0;
      r_alu_result <= '0;
      r_store_data <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_rd         <= '0;
    end else if (!w_stall) begin
      r_valid      <= ex_valid & ~flush;
      r_alu_result <= ex_alu_result;
      r_store_data <= ex_store_data;
      r_mem_read   <= ex_mem_read;
      r_mem_write  <= ex_mem_write;
      r_reg_write  <= ex_reg_write;
      r_mem_to_reg <= ex_mem_to_reg;
      r_rd         <= ex_rd;
    end
  end

  // Stalled cycles push a bubble so a waiting load writes back exactly once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      fault        <= 1'b0;
      fault_addr   <= '0;
    end else if (w_stall) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      fault        <= 1'b0;
    end else begin
      wb_valid     <= r_valid & ~w_bad;
      wb_reg_write <= r_valid & r_reg_write & ~w_bad;
      wb_rd        <= r_rd;
      wb_data      <= r_mem_to_reg ? mem_read_data : r_alu_result;
      fault        <= r_valid & w_bad;
      if (r_valid && w_bad) begin
        fault_addr <= r_alu_result;
      end
    end
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory (MEM) stage of the pipelined processor: holds the EX/MEM pipeline register and drives the data RAM's address, write_data, MemWrite and MemRead pins.
- Returns load data to the MEM/WB register and stalls the front end for configurable load wait cycles.
- Suppresses misaligned and out-of-range accesses and raises a fault pulse.
- Exports MEM-stage forwarding information to the hazard unit.

Parameters:
DATA_W, 32, data and address width
DEPTH, 32, number of RAM words; legal word index is 0..DEPTH-1
RD_LATENCY, 1, extra wait cycles per load (0..7)
REG_W, 5, destination register index width

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  replace incoming EX op with bubble (sampled only when mem_stall=0)
ex_valid  in  1  EX op valid
ex_alu_result  in  DATA_W  byte address or ALU result
ex_store_data  in  DATA_W  store data
ex_mem_read  in  1  load
ex_mem_write  in  1  store
ex_reg_write  in  1  writes register file
ex_mem_to_reg  in  1  write-back selects load data
ex_rd  in  REG_W  destination register
mem_address  out  DATA_W  RAM word index
mem_write_data  out  DATA_W  RAM write data
mem_write  out  1  RAM MemWrite
mem_read  out  1  RAM MemRead
mem_read_data  in  DATA_W  RAM read_data
mem_stall  out  1  freeze PC, IF/ID, ID/EX
fwd_valid  out  1  MEM op valid and writes a register
fwd_rd  out  REG_W  MEM-stage destination
fwd_data  out  DATA_W  MEM-stage ALU result
wb_valid  out  1  MEM/WB entry valid
wb_reg_write  out  1  write-back enable
wb_rd  out  REG_W  write-back register
wb_data  out  DATA_W  write-back data
fault  out  1  one-cycle pulse on a suppressed access
fault_addr  out  DATA_W  byte address of the last fault

Behaviour:
- Reset (reset_n=0, asynchronous): all EX/MEM and MEM/WB fields, fault, fault_addr and the wait counter go to 0; FSM enters RUN.
- Consequences of reset: mem_write, mem_read, mem_stall, wb_valid and fwd_valid all read 0. Reset mid-wait discards the pending load; no write-back occurs.
- EX/MEM capture on each posedge:
  - mem_stall=1: hold all fields.
  - Otherwise, flush=1: capture valid=0.
  - Otherwise: capture all ex_* fields.
- Address check for the held op:
  - word index = alu_result[DATA_W-1:2], zero-extended.
  - misalign = (mem_read|mem_write) and alu_result[1:0]!=0.
  - range = (mem_read|mem_write) and index >= DEPTH.
  - bad = misalign | range.
- RAM drive (combinational from EX/MEM):
  - mem_address = index.
  - mem_write_data = store_data.
  - mem_write = valid & mem_write & !bad.
  - mem_read = valid & mem_read & !bad.
- Stores never stall, so mem_write lasts exactly one cycle per store.
- FSM RUN:
  - A valid good load with RD_LATENCY>0: load counter = RD_LATENCY, assert mem_stall, go to WAIT.
  - Any other op completes this cycle.
- FSM WAIT:
  - mem_stall=1 and mem_read stays asserted.
  - Counter decrements each cycle. When counter==1, mem_stall drops to 0, the load completes, and the FSM returns to RUN.
  - Load occupancy in MEM = RD_LATENCY+1 cycles.
- Completion cycle, MEM/WB update on the next edge:
  - wb_valid = valid & !bad.
  - wb_reg_write = reg_write & !bad.
  - wb_rd = rd.
  - wb_data = mem_to_reg ? mem_read_data : alu_result.
- Stalled (non-completion) cycles: MEM/WB captures a bubble (wb_valid=0, wb_reg_write=0), so there is no duplicate write-back.
- Fault: on completion of a valid bad op, fault=1 for one cycle and fault_addr = alu_result. The op becomes a bubble; there is no RAM access.
- Forwarding:
  - fwd_valid = valid & reg_write & !mem_to_reg & !bad.
  - fwd_data = alu_result.
  - Loads are never forwarded from MEM.
- Back-to-back loads: the second load is captured on the edge the first completes, then waits its own RD_LATENCY.
- Flush asserted during WAIT is ignored; the hazard unit holds it until mem_stall=0.

Test Plan:
- Reset: assert reset_n=0 mid-run -> all outputs 0 immediately (asynchronous); release -> FSM in RUN, mem_stall=0.
- Load, RD_LATENCY=1, RAM word 5 = 109: load with alu_result=20, rd=3 -> mem_read=1 for 2 cycles, mem_address=5, mem_stall=1 for 1 cycle, then wb_valid=1, wb_rd=3, wb_data=109. The prior cycle has wb_valid=0.
- Store: alu_result=28, store_data=0xDEAD -> mem_write=1 for exactly 1 cycle with mem_address=7; no stall; then wb_valid=1, wb_reg_write=0.
- Faults:
  - Load with alu_result=22 -> misaligned: mem_read=0, fault pulse, fault_addr=22, wb_valid=0.
  - Store with alu_result=128 -> out of range: mem_write=0, fault pulse, fault_addr=128.
- ALU op then load, RD_LATENCY=3: ADD result 77 to rd=4 -> fwd_valid=1, fwd_rd=4, fwd_data=77, wb_data=77. The following load stalls for 3 cycles and completes once. A flush held during the stall takes effect only on the edge after mem_stall falls.
- RD_LATENCY=0: consecutive loads from words 0 and 1 -> mem_stall never asserts; wb_data gives each word's value on consecutive cycles.
